// File: rtl/urv_writeback.sv
// urv_writeback: writeback stage of the uRV pipeline.
// Registers ALU results for the register file, waits for data-memory
// responses on loads and performs byte/halfword lane extraction with
// sign or zero extension. The bypass port is a copy of the registered
// write port, so forwarding always sees exactly what is written.
// Optional feature: define URV_WB_LOAD_TIMEOUT_EN to abort loads that get
// no response within LOAD_TIMEOUT cycles (reported on w_load_fault_o).
module urv_writeback #(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_stall_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic [4:0]  w_rd_o,
  output logic [31:0] w_rd_value_o,
  output logic        w_rd_store_o,
  output logic        w_bypass_rd_write_o,
  output logic [31:0] w_bypass_rd_value_o,
  output logic        w_stall_req_o,
  output logic        w_load_fault_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_LOAD = 2'd1,
    S_LOAD_WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] value_q, value_d;
  logic        store_q, store_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_fun_q, ld_fun_d;
  logic [1:0]  ld_addr_q, ld_addr_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        fault_q;
  logic        timeout_hit;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_data;

`ifdef URV_WB_LOAD_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Wait counter: zero outside WAIT_LOAD, so it starts from 0 on every entry.
  always_comb begin
    cnt_d = 8'd0;
    if (state_q == S_WAIT_LOAD) cnt_d = cnt_q + 8'd1;
  end

  // A done strobe in the same cycle as the limit takes priority over the abort.
  assign timeout_hit = (state_q == S_WAIT_LOAD) && !dm_load_done_i &&
                       (cnt_q == 8'(LOAD_TIMEOUT));

  // Wait counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
  wire [7:0] unused_load_timeout = 8'(LOAD_TIMEOUT);
`endif

  // Little-endian lane selection and extension of the returning load data.
  always_comb begin
    case (ld_addr_q)
      2'd0:    lane_b = dm_data_l_i[7:0];
      2'd1:    lane_b = dm_data_l_i[15:8];
      2'd2:    lane_b = dm_data_l_i[23:16];
      default: lane_b = dm_data_l_i[31:24];
    endcase
    // addr[0] is ignored for halfwords; misaligned accesses never get here.
    lane_h = ld_addr_q[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
    case (ld_fun_q)
      3'd0:    ext_data = {{24{lane_b[7]}}, lane_b};
      3'd4:    ext_data = {24'd0, lane_b};
      3'd1:    ext_data = {{16{lane_h[15]}}, lane_h};
      3'd5:    ext_data = {16'd0, lane_h};
      default: ext_data = dm_data_l_i;
    endcase
  end

  // Next-state and output-register logic; writes to x0 are never enabled.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    value_d   = value_q;
    store_d   = store_q;
    ld_rd_d   = ld_rd_q;
    ld_fun_d  = ld_fun_q;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    case (state_q)
      S_IDLE: begin
        if (!d_stall_i) begin
          store_d = 1'b0;
          if (x_valid_i && x_load_i) begin
            ld_rd_d   = x_rd_i;
            ld_fun_d  = x_fun_i;
            ld_addr_d = x_dm_addr_i;
            state_d   = S_WAIT_LOAD;
          end else if (x_valid_i && x_rd_write_i) begin
            rd_d    = x_rd_i;
            value_d = x_rd_value_i;
            store_d = (x_rd_i != 5'd0);
          end
        end
      end
      S_WAIT_LOAD: begin
        if (!d_stall_i) store_d = 1'b0;
        if (dm_load_done_i) begin
          ld_data_d = ext_data;
          state_d   = S_LOAD_WB;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_WB: begin
        if (!d_stall_i) begin
          rd_d    = ld_rd_q;
          value_d = ld_data_q;
          store_d = (ld_rd_q != 5'd0);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, output and load-capture registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rd_q      <= 5'd0;
      value_q   <= 32'd0;
      store_q   <= 1'b0;
      ld_rd_q   <= 5'd0;
      ld_fun_q  <= 3'd0;
      ld_addr_q <= 2'd0;
      ld_data_q <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      value_q   <= value_d;
      store_q   <= store_d;
      ld_rd_q   <= ld_rd_d;
      ld_fun_q  <= ld_fun_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
      fault_q   <= timeout_hit;
    end
  end

  assign w_rd_o              = rd_q;
  assign w_rd_value_o        = value_q;
  assign w_rd_store_o        = store_q;
  assign w_bypass_rd_write_o = store_q;
  assign w_bypass_rd_value_o = value_q;
  assign w_stall_req_o       = (state_q != S_IDLE);
  assign w_load_fault_o      = fault_q;

endmodule
